tohost_status_monitor: RTL

- Sits inside the test harness and generates the harness `io_success` level that the top-level driver samples every cycle.
- Consumes the DUT's tohost write stream, decodes RISC-V HTIF-style tohost words, forwards console putchar bytes through a small FIFO, and produces sticky pass/fail status with an exit code.
- Provides an optional idle watchdog that fails the test if tohost goes silent.

---
 rtl/tohost_status_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tohost_status_monitor.sv
// tohost_status_monitor: decodes HTIF-style tohost words into console bytes
// and sticky pass/fail status for the harness io_success level.
// Optional build macro TOHOST_STATUS_MONITOR_TRACE_EN adds simulation-only
// console/status printing; ports and timing are unchanged.
module tohost_status_monitor #(
  parameter int FIFO_DEPTH      = 4,
  parameter int WATCHDOG_CYCLES = 0,
  parameter int WDOG_W          = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_char,
  output logic        success,
  output logic        failure,
  output logic        timeout,
  output logic [31:0] fail_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     code;

  logic fifo_full, accept, pop, push, term;
  logic is_zero, is_put, is_exit;
  logic drain_done, wd_fire;

  // Putchar is matched before the exit bit: printable characters with the
  // LSB set would otherwise be misread as an exit request.
  assign is_zero = (req_data == 64'd0);
  assign is_put  = (req_data[63:56] == 8'h01) && (req_data[55:48] == 8'h01);
  assign is_exit = req_data[0];

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign pop        = con_valid && con_ready;
  assign push       = accept && is_put;
  assign term       = accept && !is_zero && !is_put;
  assign drain_done = (state == DRAIN) && (count == '0);
  assign con_char   = mem[rd_ptr];

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state logic; normal drain completion beats a coincident watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (term)         state_nxt = DRAIN;
        else if (wd_fire) state_nxt = DONE;
      end
      DRAIN: begin
        if (count == '0)  state_nxt = DONE;
        else if (wd_fire) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  // Handshake outputs depend only on state and occupancy, never on con_ready
  always_comb begin
    req_ready = (state == RUN) && !fifo_full;
    con_valid = (count != '0);
  end

  // Exit code captured when the terminating beat is accepted
  always_ff @(posedge clock) begin
    if (!reset)    code <= '0;
    else if (term) code <= is_exit ? req_data[32:1] : 32'hFFFF_FFFE;
  end

  // Sticky status, set once on entry to DONE
  always_ff @(posedge clock) begin
    if (!reset) begin
      success   <= 1'b0;
      failure   <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else if (state != DONE) begin
      if (drain_done) begin
        success   <= (code == 32'd0);
        failure   <= (code != 32'd0);
        fail_code <= code;
      end else if (wd_fire) begin
        failure   <= 1'b1;
        timeout   <= 1'b1;
        fail_code <= 32'hFFFF_FFFF;
      end
    end
  end

  // Console FIFO pointers and occupancy; pointers wrap as DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= req_data[7:0];
  end

  generate
    if (WATCHDOG_CYCLES > 0) begin : g_wdog
      logic [WDOG_W-1:0] wd_cnt;

      assign wd_fire = (state != DONE) && !accept &&
                       (wd_cnt == WDOG_W'(WATCHDOG_CYCLES - 1));

      // Idle counter: cleared by any accepted beat, frozen in DONE
      always_ff @(posedge clock) begin
        if (!reset)              wd_cnt <= '0;
        else if (state == DONE)  wd_cnt <= wd_cnt;
        else if (accept)         wd_cnt <= '0;
        else if (!wd_fire)       wd_cnt <= wd_cnt + WDOG_W'(1);
      end
    end else begin : g_no_wdog
      assign wd_fire = 1'b0;
    end
  endgenerate

`ifdef TOHOST_STATUS_MONITOR_TRACE_EN
  logic [31:0] trace_cyc;

  // Simulation trace: echo console bytes and report the final verdict
  always_ff @(posedge clock) begin
    if (!reset) begin
      trace_cyc <= '0;
    end else begin
      trace_cyc <= trace_cyc + 32'd1;
      if (pop) $write("%c", con_char);
      if (state != DONE && state_nxt == DONE) begin
        if (drain_done && code == 32'd0)
          $write("tohost: PASS cycle=%0d\n", trace_cyc);
        else if (drain_done)
          $write("tohost: FAIL code=%0d cycle=%0d\n", code, trace_cyc);
        else
          $write("tohost: TIMEOUT cycle=%0d\n", trace_cyc);
      end
    end
  end
`endif

endmodule
